// File: rtl/maxpool_13_2_8_1_pkg.sv
// Shared state type, default geometry and signed-max helper for the pooling stage.
package pool_pkg;

    localparam int POOL_N = 13;
    localparam int POOL_P = 2;
    localparam int POOL_W = 8;

    typedef enum logic {
        S_FIRST = 1'b0,
        S_ACC   = 1'b1
    } pool_state_t;

    // Strict compare: on a tie the earlier sample (b) is kept.
    function automatic logic signed [POOL_W-1:0] smax(
        input logic signed [POOL_W-1:0] a,
        input logic signed [POOL_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/maxpool_13_2_8_1_out_reg.sv
// One-entry valid/ready output register; reusable by any streaming stage that
// produces at most one result per accepted input.
module pool_out_reg import pool_pkg::*; #(
    parameter int W = POOL_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic signed [W-1:0] load_data,
    input  logic                load_last,
    output logic signed [W-1:0] y_data,
    output logic                y_valid,
    output logic                y_last,
    input  logic                y_ready,
    output logic                up_ready
);

    // Upstream may proceed when the slot is empty or is being drained this cycle.
    assign up_ready = ~y_valid | y_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_data  <= '0;
            y_last  <= 1'b0;
            y_valid <= 1'b0;
        end else if (load) begin
            y_data  <= load_data;
            y_last  <= load_last;
            y_valid <= 1'b1;
        end else if (y_valid && y_ready) begin
            y_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/maxpool_13_2_8_1.sv
// Streaming 1-D max-pool over non-overlapping windows of P samples per N-sample frame.
// Define POOL_PARTIAL_EN to emit the trailing partial window as the frame's last result.
module maxpool_13_2_8_1 import pool_pkg::*; #(
    parameter int N = POOL_N,
    parameter int P = POOL_P,
    parameter int W = POOL_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [W-1:0] x_data,
    input  logic                x_valid,
    output logic                x_ready,
    output logic signed [W-1:0] y_data,
    output logic                y_valid,
    input  logic                y_ready,
    output logic                y_last
);

    localparam int WC_W = (P > 1) ? $clog2(P) : 1;
    localparam int SC_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [WC_W-1:0] WIN_LAST = WC_W'(P - 1);
    localparam logic [SC_W-1:0] SMP_LAST = SC_W'(N - 1);

    pool_state_t         state, state_nxt;
    logic [WC_W-1:0]     win_cnt;
    logic [SC_W-1:0]     smp_cnt;
    logic signed [W-1:0] max_r;
    logic signed [W-1:0] cand;
    logic                xfer, win_end, frm_end, close, close_last;

    assign xfer    = x_valid & x_ready;
    assign win_end = (win_cnt == WIN_LAST);
    assign frm_end = (smp_cnt == SMP_LAST);
    // A window opener loads unconditionally so negative first samples are kept.
    assign cand    = (state == S_FIRST) ? x_data : smax(x_data, max_r);

`ifdef POOL_PARTIAL_EN
    assign close      = xfer & (win_end | frm_end);
    assign close_last = frm_end;
`else
    localparam logic [SC_W-1:0] FULL_LAST = SC_W'((N / P) * P - 1);
    // Trailing samples are swallowed, so the last full window carries the frame marker.
    assign close      = xfer & win_end;
    assign close_last = (smp_cnt == FULL_LAST);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FIRST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (xfer) begin
            state_nxt = (win_end || frm_end) ? S_FIRST : S_ACC;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_cnt <= '0;
            smp_cnt <= '0;
            max_r   <= '0;
        end else if (xfer) begin
            max_r <= cand;
            if (frm_end) begin
                smp_cnt <= '0;
                win_cnt <= '0;
            end else begin
                smp_cnt <= smp_cnt + SC_W'(1);
                win_cnt <= win_end ? '0 : win_cnt + WC_W'(1);
            end
        end
    end

    pool_out_reg #(.W(W)) u_out (
        .clk       (clk),
        .reset     (reset),
        .load      (close),
        .load_data (cand),
        .load_last (close_last),
        .y_data    (y_data),
        .y_valid   (y_valid),
        .y_last    (y_last),
        .y_ready   (y_ready),
        .up_ready  (x_ready)
    );

endmodule

// File: tb/tb_maxpool_13_2_8_1.sv
// Scoreboard bench for maxpool_13_2_8_1: frame results are predicted when frames are queued.
module tb_maxpool_13_2_8_1;

    localparam int N  = 13;
    localparam int P  = 2;
    localparam int W  = 8;
    localparam int NW = N / P;
`ifdef POOL_PARTIAL_EN
    localparam bit PART = 1'b1;
    localparam int NRES = NW + (((N % P) != 0) ? 1 : 0);
`else
    localparam bit PART = 1'b0;
    localparam int NRES = NW;
`endif

    typedef logic signed [W-1:0] smp_t;

    logic   clk = 1'b0;
    logic   reset;
    smp_t   x_data;
    logic   x_valid;
    logic   x_ready;
    smp_t   y_data;
    logic   y_valid;
    logic   y_ready;
    logic   y_last;

    smp_t   tx_q[$];
    smp_t   exp_d[$];
    logic   exp_l[$];
    smp_t   ed;
    logic   el;
    int     n_chk = 0;
    int     n_fail = 0;
    int     n_out = 0;
    int     n_last = 0;
    int     last_cyc = 0;
    bit     mon_en = 1'b0;

    always #5 clk = ~clk;

    maxpool_13_2_8_1 dut (
        .clk     (clk),
        .reset   (reset),
        .x_data  (x_data),
        .x_valid (x_valid),
        .x_ready (x_ready),
        .y_data  (y_data),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .y_last  (y_last)
    );

    // Output monitor: every output transfer is compared against the scoreboard head.
    always @(negedge clk) begin
        if (mon_en && y_valid && y_ready) begin
            n_out++;
            if (y_last) n_last++;
            n_chk++;
            if (exp_d.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got y_data=%0d y_last=%0b, required no output", y_data, y_last);
            end else begin
                ed = exp_d.pop_front();
                el = exp_l.pop_front();
                if (y_data !== ed || y_last !== el) begin
                    n_fail++;
                    $display("FAIL result: got y_data=%0d y_last=%0b, required y_data=%0d y_last=%0b",
                             y_data, y_last, ed, el);
                end
            end
        end
    end

    // Queue a frame for driving and predict its pooled results.
    task automatic add_frame(input smp_t f [N]);
        smp_t m;
        for (int i = 0; i < N; i++) tx_q.push_back(f[i]);
        for (int w = 0; w < NW; w++) begin
            m = f[w*P];
            for (int k = 1; k < P; k++) if (f[w*P+k] > m) m = f[w*P+k];
            exp_d.push_back(m);
            exp_l.push_back((w == NW - 1) && !(PART && (N % P) != 0));
        end
        if (PART && (N % P) != 0) begin
            m = f[NW*P];
            for (int k = NW*P + 1; k < N; k++) if (f[k] > m) m = f[k];
            exp_d.push_back(m);
            exp_l.push_back(1'b1);
        end
    endtask

    // Push all queued samples with random valid/ready duty; stop once results drain.
    task automatic drive_all(input int vpct, input int rpct, input int budget);
        int i;
        int cyc;
        bit acc;
        i = 0;
        cyc = 0;
        while ((i < tx_q.size() || exp_d.size() != 0) && cyc < budget) begin
            x_valid = (i < tx_q.size()) && ($urandom_range(99) < vpct);
            x_data  = x_valid ? tx_q[i] : smp_t'($urandom_range(255));
            y_ready = ($urandom_range(99) < rpct);
            @(negedge clk);
            acc = x_valid && x_ready;
            @(posedge clk);
            #1;
            if (acc) i++;
            cyc++;
        end
        x_valid  = 1'b0;
        y_ready  = 1'b1;
        last_cyc = cyc;
        n_chk++;
        if (cyc >= budget) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d samples and %0d results pending after %0d cycles, required 0",
                     tx_q.size() - i, exp_d.size(), cyc);
        end
        tx_q.delete();
    endtask

    task automatic test_reset();
        mon_en  = 1'b0;
        reset   = 1'b1;
        x_valid = 1'b0;
        x_data  = '0;
        y_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (y_valid !== 1'b0 || y_data !== 8'sd0 || y_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%0b data=%0d last=%0b, required 0/0/0", y_valid, y_data, y_last);
        end
        reset = 1'b0;
        @(negedge clk);
        n_chk++;
        if (x_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_x_ready: got %0b, required 1", x_ready);
        end
        @(posedge clk);
        #1;
        y_ready = 1'b1;
        mon_en  = 1'b1;
    endtask

    task automatic test_frame();
        smp_t f [N] = '{0, 5, 3, 3, 7, 2, 0, 0, 1, 9, 4, 4, 6};
        int o0 = n_out;
        int l0 = n_last;
        add_frame(f);
        drive_all(100, 100, 200);
        n_chk++;
        if (n_out - o0 != NRES) begin
            n_fail++;
            $display("FAIL frame_count: got %0d results, required %0d", n_out - o0, NRES);
        end
        n_chk++;
        if (n_last - l0 != 1) begin
            n_fail++;
            $display("FAIL frame_last: got %0d last markers, required 1", n_last - l0);
        end
        n_chk++;
        if (last_cyc > N + 1) begin
            n_fail++;
            $display("FAIL throughput: got %0d cycles, required at most %0d", last_cyc, N + 1);
        end
    endtask

    task automatic test_negative();
        smp_t f [N] = '{-3, -7, -1, -128, 127, -128, -5, -5, 0, -1, -2, -3, -9};
        int o0 = n_out;
        add_frame(f);
        drive_all(100, 100, 200);
        n_chk++;
        if (n_out - o0 != NRES) begin
            n_fail++;
            $display("FAIL negative_count: got %0d results, required %0d", n_out - o0, NRES);
        end
    endtask

    task automatic test_backpressure();
        smp_t f [N] = '{0, 5, 3, 3, 7, 2, 0, 0, 1, 9, 4, 4, 6};
        int o0 = n_out;
        add_frame(f);
        tx_q.delete();
        for (int i = 2; i < N; i++) tx_q.push_back(f[i]);
        y_ready = 1'b0;
        x_valid = 1'b1;
        x_data  = f[0];
        @(negedge clk);
        n_chk++;
        if (x_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_empty: got x_ready=%0b, required 1", x_ready);
        end
        @(posedge clk);
        #1;
        x_data = f[1];
        @(posedge clk);
        #1;
        x_data = f[2];
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_chk++;
            if (x_ready !== 1'b0 || y_valid !== 1'b1 || y_data !== 8'sd5 || y_last !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_stall: got x_ready=%0b y_valid=%0b y_data=%0d y_last=%0b, required 0/1/5/0",
                         x_ready, y_valid, y_data, y_last);
            end
            @(posedge clk);
            #1;
        end
        drive_all(100, 100, 200);
        n_chk++;
        if (n_out - o0 != NRES) begin
            n_fail++;
            $display("FAIL bp_count: got %0d results, required %0d", n_out - o0, NRES);
        end
    endtask

    task automatic test_random();
        smp_t f [N];
        int o0 = n_out;
        int l0 = n_last;
        for (int fr = 0; fr < 10; fr++) begin
            for (int i = 0; i < N; i++) f[i] = smp_t'($urandom_range(255));
            add_frame(f);
        end
        drive_all(60, 60, 3000);
        n_chk++;
        if (n_out - o0 != 10 * NRES) begin
            n_fail++;
            $display("FAIL random_count: got %0d results, required %0d", n_out - o0, 10 * NRES);
        end
        n_chk++;
        if (n_last - l0 != 10) begin
            n_fail++;
            $display("FAIL random_last: got %0d last markers, required 10", n_last - l0);
        end
    endtask

    task automatic test_reset_midframe();
        smp_t pre [5] = '{10, 20, 30, 40, 100};
        smp_t f [N]   = '{0, 5, 3, 3, 7, 2, 0, 0, 1, 9, 4, 4, 6};
        int o0;
        mon_en  = 1'b0;
        y_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            x_valid = 1'b1;
            x_data  = pre[i];
            @(posedge clk);
            #1;
        end
        x_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        n_chk++;
        if (y_valid !== 1'b0 || y_data !== 8'sd0 || y_last !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got valid=%0b data=%0d last=%0b, required 0/0/0", y_valid, y_data, y_last);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_chk++;
        if (x_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_x_ready: got %0b, required 1", x_ready);
        end
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        o0 = n_out;
        add_frame(f);
        drive_all(100, 100, 200);
        n_chk++;
        if (n_out - o0 != NRES) begin
            n_fail++;
            $display("FAIL midreset_count: got %0d results, required %0d", n_out - o0, NRES);
        end
    endtask

    task automatic test_back_to_back();
        smp_t f1 [N] = '{100, 100, 100, 100, 100, 100, 100, 100, 100, 100, 100, 100, 100};
        smp_t f2 [N] = '{-50, -60, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
        int o0 = n_out;
        int l0 = n_last;
        add_frame(f1);
        add_frame(f2);
        drive_all(100, 100, 200);
        n_chk++;
        if (n_last - l0 != 2) begin
            n_fail++;
            $display("FAIL b2b_last: got %0d last markers, required 2", n_last - l0);
        end
        n_chk++;
        if (n_out - o0 != 2 * NRES) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results, required %0d", n_out - o0, 2 * NRES);
        end
        n_chk++;
        if (last_cyc > 2 * N + 1) begin
            n_fail++;
            $display("FAIL b2b_throughput: got %0d cycles, required at most %0d", last_cyc, 2 * N + 1);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_negative();
        test_backpressure();
        test_random();
        test_reset_midframe();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
